wave_capture: RTL
=================

Name: wave_capture

Overview:
- Acquisition-side writer for the oscilloscope waveform path. Stores ADC samples around a trigger event into a ping-pong frame buffer.
- Serves one frozen frame to the HDMI waveform renderer through that renderer's wave_addr / wave_data / outrange / wr_over interface.
- Swaps banks only when the renderer signals frame-draw completion, so the display never tears.

Parameters:
- DEPTH, 500, samples per frame (one per waveform column)
- AW, 10, address width
- DW, 12, ADC sample width
- PRE_DEPTH, 250, samples kept before the trigger
- AUTO_TIMEOUT, 24'd2_000_000, lcd_pclk cycles in ARMED before auto mode forces a trigger

Ports:
- lcd_pclk  in  1  single system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- ad_data  in  DW  ADC sample, unsigned
- ad_valid  in  1  sample strobe (decimated rate)
- run  in  1  1 = acquire, 0 = stop
- trig_level  in  DW  trigger threshold
- trig_edge  in  1  0 = rising, 1 = falling
- auto_mode  in  1  enable timeout trigger
- h_shift  in  10  horizontal shift; bit9 = 0 shifts right (+), 1 shifts left (−); magnitude in [8:0]
- wave_data_req  in  1  renderer read enable
- wave_addr  in  AW  renderer column index 0..DEPTH-1
- wr_over  in  1  one-cycle pulse: renderer finished drawing the frame
- wave_data  out  DW  sample for wave_addr
- outrange  out  1  shifted index falls outside the frame
- trig_flag  out  1  one-cycle pulse on a real trigger
- auto_flag  out  1  one-cycle pulse on a forced trigger
- frame_ready  out  1  level; high while in DONE

Behaviour:
- Reset (async): state = IDLE, wr_bank = 1, rd_bank = ~wr_bank = 0, all counters 0, prev_sample = 0, trig_addr = 0. All outputs are 0. RAM contents are not reset.
- States:
  - IDLE: if run = 1, go to PRE.
  - PRE: write each ad_valid sample at wr_ptr. wr_ptr increments mod DEPTH (499 -> 0). After PRE_DEPTH samples, go to ARMED.
  - ARMED: keep writing circularly. Trigger on a sample that is valid and meets the edge rule:
    - Rising: prev_sample < trig_level and ad_data >= trig_level.
    - Falling: prev_sample > trig_level and ad_data <= trig_level.
    - Entering PRE clears prev_valid, so the first sample of an acquisition can never trigger.
  - Auto trigger: timeout counter runs in ARMED only and resets on entry. When it reaches AUTO_TIMEOUT-1 with auto_mode = 1, the next valid sample is the trigger.
  - On trigger: latch trig_addr = wr_ptr, pulse trig_flag (real) or auto_flag (forced) in the same cycle, go to POST.
  - POST: the trigger sample counts as post-sample 0. After DEPTH-PRE_DEPTH samples (250), go to DONE.
  - DONE: no writes. On wr_over: toggle wr_bank, latch start_idx = (trig_addr − PRE_DEPTH) mod DEPTH for the newly readable bank, then go to PRE if run = 1, else IDLE.
- Stop: run = 0 in PRE or ARMED aborts to IDLE with no swap; the display keeps the last frame. run = 0 in POST lets the capture complete.
- Simultaneous events:
  - wr_over in the same cycle as the POST -> DONE transition is ignored; the swap waits for the next wr_over.
  - ad_valid in the same cycle as a state transition is handled by the current state.
- Read path, 1-cycle registered latency:
  - idx = wave_addr ± h_shift[8:0], computed as 12-bit signed.
  - If idx < 0 or idx >= DEPTH: outrange = 1 and wave_data = 0.
  - Otherwise: phys = start_idx + idx, with one conditional subtract of DEPTH; wave_data = ram[rd_bank][phys] and outrange = 0.
  - If wave_data_req = 0: wave_data = 0 and outrange = 0.
- Write and read always target opposite banks, so there are no collisions.

Decomposition:
- Shared package: state encoding (IDLE/PRE/ARMED/POST/DONE), DEPTH, DW, AW, PRE_DEPTH.
- Sub-module wave_dpram: simple dual-port RAM, 2*DEPTH x DW, one write port and one registered read port. Address = {bank, index}.

Test Plan:
- Rising trigger with no shift:
  - Stimulus: ramp 0..4095 step 16 on every ad_valid, trig_level = 2048, trig_edge = 0, h_shift = 0, pulse wr_over after POST completes.
  - Required: trig_flag exactly once; a read at wave_addr = 250 returns 2048 one cycle later; address 249 returns 2032.
- Falling edge:
  - Stimulus: descending ramp, trig_edge = 1, trig_level = 1000.
  - Required: trigger on the first sample <= 1000; read column 250 = that sample value.
- Auto trigger:
  - Stimulus: constant ad_data = 100, trig_level = 2048, auto_mode = 1, AUTO_TIMEOUT overridden to 64.
  - Required: auto_flag on the first valid sample after 64 cycles in ARMED; no trig_flag.
  - Same stimulus with auto_mode = 0: stays in ARMED indefinitely.
- h_shift and outrange:
  - h_shift = 10'h00A (+10): wave_addr = 495 gives outrange = 1 and wave_data = 0; wave_addr = 489 gives the sample at idx 499.
  - h_shift = 10'h205 (−5): wave_addr = 4 gives outrange = 1.
- Wrap-around: arrange trig_addr = 100. Required: start_idx = 350; wave_addr = 200 maps to phys 50.
- Stop, reset and collision:
  - run deasserted in ARMED: back to IDLE, frame_ready = 0, read data unchanged.
  - rst_n pulsed in POST: all outputs 0 on the next edge.
  - wr_over coincident with POST completion: no swap until the second wr_over.

Source files
------------

// File: rtl/wave_capture_pkg.sv
// Shared constants for the waveform capture path: frame geometry, sample
// width and FSM state encoding.
package wave_capture_pkg;

    localparam int unsigned WAVE_DEPTH     = 500;  // samples per frame
    localparam int unsigned WAVE_AW        = 10;   // frame index width
    localparam int unsigned WAVE_DW        = 12;   // ADC sample width
    localparam int unsigned WAVE_PRE_DEPTH = 250;  // samples kept before trigger

    typedef logic [WAVE_DW-1:0] sample_t;

    // Capture FSM states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE   = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_POST  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/wave_capture_if.sv
// Renderer read interface for the frozen waveform frame.
//   master (renderer): drives wave_data_req, wave_addr, wr_over
//   slave  (capture) : returns wave_data, outrange one cycle later
interface wave_capture_if;
    import wave_capture_pkg::*;

    logic               wave_data_req;
    logic [WAVE_AW-1:0] wave_addr;
    logic               wr_over;
    sample_t            wave_data;
    logic               outrange;

    modport master (
        output wave_data_req, wave_addr, wr_over,
        input  wave_data, outrange
    );

    modport slave (
        input  wave_data_req, wave_addr, wr_over,
        output wave_data, outrange
    );

endinterface

// File: rtl/wave_dpram.sv
// Ping-pong frame store: one write port, one registered read port.
// Address is {bank, index}; each bank spans 2**AW entries of which only the
// first DEPTH are used. A read with rd_en low returns zero on the next cycle.
//   lcd_pclk, rst_n : clock, async active-low reset (read register only)
//   we/wr_addr/wr_data : write port
//   rd_en/rd_addr/rd_data : registered read port
module wave_dpram #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 12
) (
    input  logic          lcd_pclk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW:0]   wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW:0]   rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int unsigned ENTRIES = 2 ** (AW + 1);

    logic [DW-1:0] mem [ENTRIES];

    // Write port; contents are never reset
    always_ff @(posedge lcd_pclk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read, forced to zero when not enabled
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/wave_capture.sv
// Triggered waveform capture into a ping-pong frame buffer, with a read port
// serving the frozen bank to the HDMI renderer. Banks swap only on wr_over.
//   lcd_pclk, rst_n        : clock, async active-low reset
//   ad_data, ad_valid      : ADC sample stream
//   run, trig_level, trig_edge, auto_mode, h_shift : user controls
//   rd (slave)             : renderer read interface
//   trig_flag, auto_flag   : one-cycle trigger pulses (real / forced)
//   frame_ready            : high while a completed frame awaits wr_over
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int unsigned DEPTH        = WAVE_DEPTH,
    parameter int unsigned AW           = WAVE_AW,
    parameter int unsigned DW           = WAVE_DW,
    parameter int unsigned PRE_DEPTH    = WAVE_PRE_DEPTH,
    parameter logic [23:0] AUTO_TIMEOUT = 24'd2_000_000
) (
    input  logic          lcd_pclk,
    input  logic          rst_n,
    input  logic [DW-1:0] ad_data,
    input  logic          ad_valid,
    input  logic          run,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_edge,
    input  logic          auto_mode,
    input  logic [9:0]    h_shift,
    wave_capture_if.slave rd,
    output logic          trig_flag,
    output logic          auto_flag,
    output logic          frame_ready
);

    localparam int unsigned POST_DEPTH = DEPTH - PRE_DEPTH;
    localparam int unsigned IW         = AW + 2;  // signed shifted-index width

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [23:0]   to_cnt_q, to_cnt_d;
    logic          timed_out_q, timed_out_d;
    logic [DW-1:0] prev_sample_q, prev_sample_d;
    logic          prev_valid_q, prev_valid_d;
    logic [AW-1:0] trig_addr_q, trig_addr_d;
    logic [AW-1:0] start_idx_q, start_idx_d;
    logic          wr_bank_q, wr_bank_d;
    logic          trig_flag_d, auto_flag_d;
    logic          outrange_q;
    logic          wr_en_c;

    logic [AW-1:0] ptr_inc_c;
    logic [AW-1:0] start_c;
    logic          edge_hit_c;
    logic          force_c;
    logic [IW-1:0] idx_c;
    logic [IW-1:0] sum_c;
    logic [IW-1:0] phys_full_c;
    logic [AW-1:0] phys_c;
    logic          oor_c;
    logic [DW-1:0] rd_data;

    // Circular write pointer advance
    assign ptr_inc_c = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);

    // First pre-trigger sample position, modulo DEPTH
    assign start_c = (trig_addr_q >= AW'(PRE_DEPTH)) ? trig_addr_q - AW'(PRE_DEPTH)
                                                     : trig_addr_q + AW'(DEPTH - PRE_DEPTH);

    // Edge detector against the previous sample; needs one sample of history
    assign edge_hit_c = prev_valid_q &&
                        (trig_edge ? ((prev_sample_q > trig_level) && (ad_data <= trig_level))
                                   : ((prev_sample_q < trig_level) && (ad_data >= trig_level)));

    assign force_c = auto_mode && timed_out_q;

    // Next-state and capture control
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        cnt_d         = cnt_q;
        to_cnt_d      = to_cnt_q;
        timed_out_d   = timed_out_q;
        prev_sample_d = prev_sample_q;
        prev_valid_d  = prev_valid_q;
        trig_addr_d   = trig_addr_q;
        start_idx_d   = start_idx_q;
        wr_bank_d     = wr_bank_q;
        trig_flag_d   = 1'b0;
        auto_flag_d   = 1'b0;
        wr_en_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d      = ST_PRE;
                    wr_ptr_d     = '0;
                    cnt_d        = '0;
                    prev_valid_d = 1'b0;
                end
            end

            ST_PRE: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (ad_valid) begin
                    wr_en_c       = 1'b1;
                    wr_ptr_d      = ptr_inc_c;
                    prev_sample_d = ad_data;
                    prev_valid_d  = 1'b1;
                    if (cnt_q == AW'(PRE_DEPTH - 1)) begin
                        state_d     = ST_ARMED;
                        cnt_d       = '0;
                        to_cnt_d    = '0;
                        timed_out_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end

            ST_ARMED: begin
                // Saturating timeout; once reached, the next valid sample is forced
                if (to_cnt_q == AUTO_TIMEOUT - 24'd1) begin
                    timed_out_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 24'd1;
                end
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (ad_valid) begin
                    wr_en_c       = 1'b1;
                    wr_ptr_d      = ptr_inc_c;
                    prev_sample_d = ad_data;
                    prev_valid_d  = 1'b1;
                    if (edge_hit_c || force_c) begin
                        trig_addr_d = wr_ptr_q;
                        trig_flag_d = edge_hit_c;
                        auto_flag_d = ~edge_hit_c;
                        cnt_d       = AW'(1);  // trigger sample is post-sample 0
                        state_d     = ST_POST;
                    end
                end
            end

            ST_POST: begin
                if (ad_valid) begin
                    wr_en_c       = 1'b1;
                    wr_ptr_d      = ptr_inc_c;
                    prev_sample_d = ad_data;
                    if (cnt_q == AW'(POST_DEPTH - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end

            ST_DONE: begin
                if (rd.wr_over) begin
                    wr_bank_d   = ~wr_bank_q;
                    start_idx_d = start_c;
                    if (run) begin
                        state_d      = ST_PRE;
                        wr_ptr_d     = '0;
                        cnt_d        = '0;
                        prev_valid_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            cnt_q         <= '0;
            to_cnt_q      <= '0;
            timed_out_q   <= 1'b0;
            prev_sample_q <= '0;
            prev_valid_q  <= 1'b0;
            trig_addr_q   <= '0;
            start_idx_q   <= '0;
            wr_bank_q     <= 1'b1;
            trig_flag     <= 1'b0;
            auto_flag     <= 1'b0;
            frame_ready   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            to_cnt_q      <= to_cnt_d;
            timed_out_q   <= timed_out_d;
            prev_sample_q <= prev_sample_d;
            prev_valid_q  <= prev_valid_d;
            trig_addr_q   <= trig_addr_d;
            start_idx_q   <= start_idx_d;
            wr_bank_q     <= wr_bank_d;
            trig_flag     <= trig_flag_d;
            auto_flag     <= auto_flag_d;
            frame_ready   <= (state_d == ST_DONE);
        end
    end

    // Read address: shifted column, range check, rotate by start_idx
    assign idx_c = h_shift[9] ? IW'(rd.wave_addr) - IW'(h_shift[8:0])
                              : IW'(rd.wave_addr) + IW'(h_shift[8:0]);
    assign oor_c       = idx_c[IW-1] || (idx_c >= IW'(DEPTH));
    assign sum_c       = IW'(start_idx_q) + idx_c;
    assign phys_full_c = (sum_c >= IW'(DEPTH)) ? sum_c - IW'(DEPTH) : sum_c;
    assign phys_c      = AW'(phys_full_c);

    // outrange aligned with the registered RAM read
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            outrange_q <= 1'b0;
        end else begin
            outrange_q <= rd.wave_data_req && oor_c;
        end
    end

    wave_dpram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .lcd_pclk (lcd_pclk),
        .rst_n    (rst_n),
        .we       (wr_en_c),
        .wr_addr  ({wr_bank_q, wr_ptr_q}),
        .wr_data  (ad_data),
        .rd_en    (rd.wave_data_req && !oor_c),
        .rd_addr  ({~wr_bank_q, phys_c}),
        .rd_data  (rd_data)
    );

    assign rd.wave_data = rd_data;
    assign rd.outrange  = outrange_q;

endmodule
